// File: rtl/copad_readout.sv
// ============================================================================
// Module   : copad_readout
// Brief    : Buffers co-pad match events in a FIFO, serialises matched clusters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module copad_readout #(
  parameter int DEPTH   = 4,
  parameter int MXCLSTB = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [7:0]         match,
  input  logic               any_match,
  input  logic [MXCLSTB-1:0] cluster0,
  input  logic [MXCLSTB-1:0] cluster1,
  input  logic [MXCLSTB-1:0] cluster2,
  input  logic [MXCLSTB-1:0] cluster3,
  input  logic [MXCLSTB-1:0] cluster4,
  input  logic [MXCLSTB-1:0] cluster5,
  input  logic [MXCLSTB-1:0] cluster6,
  input  logic [MXCLSTB-1:0] cluster7,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [MXCLSTB-1:0] out_cluster,
  output logic [2:0]         out_idx,
  output logic               out_last,
  output logic [15:0]        event_count,
  output logic [15:0]        drop_count,
  output logic               fifo_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 8 + 8 * MXCLSTB;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [7:0]         pend_q, pend_d;
  logic [MXCLSTB-1:0] clus_q [8];
  logic [15:0]        event_count_q, drop_count_q;

  logic [EW-1:0]      in_entry;
  logic [EW-1:0]      head_entry;
  logic               push_req, push_ok, drop, pop, load, full;
  logic [2:0]         beat_idx;
  logic [7:0]         pend_rest;
  logic               pend_one;

  // Entry layout: match in the low byte, cluster k at slot k above it.
  assign in_entry = {cluster7, cluster6, cluster5, cluster4,
                     cluster3, cluster2, cluster1, cluster0, match};
  assign head_entry = mem_q[rd_ptr_q];

  assign full     = (count_q == CW'(DEPTH));
  assign push_req = enable & any_match & (|match);
  assign pop      = (state_q == IDLE) & (count_q != '0);
  // A full FIFO still takes a new event when the head leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & ~push_ok;
  assign count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  always_comb begin
    beat_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (pend_q[k]) beat_idx = 3'(k);
    end
  end

  assign pend_rest = pend_q & (pend_q - 8'd1);
  assign pend_one  = (pend_rest == 8'd0);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    load        = 1'b0;
    out_valid   = 1'b0;
    out_cluster = '0;
    out_idx     = 3'd0;
    out_last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          load    = 1'b1;
          pend_d  = head_entry[7:0];
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid   = 1'b1;
        out_cluster = clus_q[beat_idx];
        out_idx     = beat_idx;
        out_last    = pend_one;
        if (out_ready) begin
          pend_d = pend_rest;
          if (pend_one) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_q        <= 8'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      event_count_q <= 16'd0;
      drop_count_q  <= 16'd0;
      for (int k = 0; k < 8; k++) clus_q[k] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      if (load) begin
        for (int k = 0; k < 8; k++) clus_q[k] <= head_entry[8 + k*MXCLSTB +: MXCLSTB];
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && event_count_q != 16'hFFFF) event_count_q <= event_count_q + 16'd1;
      if (drop && drop_count_q != 16'hFFFF)     drop_count_q  <= drop_count_q + 16'd1;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= in_entry;
  end

  assign event_count = event_count_q;
  assign drop_count  = drop_count_q;
  assign fifo_full   = full;

endmodule

`default_nettype wire

// File: tb/tb_copad_readout.sv
// ============================================================================
// Module   : tb_copad_readout
// Brief    : Directed self-checking bench for copad_readout with an event model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_copad_readout;

  localparam int DEPTH = 4;
  localparam int W     = 14;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         any_match = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   match = 8'd0;
  logic [W-1:0] cl [8];

  logic         out_valid;
  logic [W-1:0] out_cluster;
  logic [2:0]   out_idx;
  logic         out_last;
  logic [15:0]  event_count;
  logic [15:0]  drop_count;
  logic         fifo_full;

  copad_readout #(.DEPTH(DEPTH), .MXCLSTB(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .match(match),
    .any_match(any_match),
    .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
    .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
    .out_ready(out_ready), .out_valid(out_valid), .out_cluster(out_cluster),
    .out_idx(out_idx), .out_last(out_last), .event_count(event_count),
    .drop_count(drop_count), .fifo_full(fifo_full)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: a bounded queue of events and the beat list of the one in flight.
  typedef struct packed {
    logic [7:0]     m;
    logic [8*W-1:0] c;
  } ev_t;

  ev_t            mq[$];
  logic [W+2:0]   bq[$];
  logic [W+3:0]   log_q[$];
  bit             busy = 0;
  bit             armed = 0;
  bit             m_pop;
  int             m_ec = 0;
  int             m_dc = 0;
  ev_t            m_head, m_new;
  logic [W+2:0]   m_tmp;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      bq.delete();
      busy  = 0;
      m_ec  = 0;
      m_dc  = 0;
      armed = 1;
    end else begin
      m_pop = !busy && (mq.size() > 0);
      if (busy && out_ready) begin
        m_tmp = bq.pop_front();
        if (bq.size() == 0) busy = 0;
      end
      if (m_pop) begin
        m_head = mq.pop_front();
        for (int k = 0; k < 8; k++)
          if (m_head.m[k]) bq.push_back({3'(k), m_head.c[k*W +: W]});
        busy = 1;
      end
      if (enable && any_match && match != 8'd0) begin
        if (mq.size() < DEPTH) begin
          m_new.m = match;
          m_new.c = {cl[7], cl[6], cl[5], cl[4], cl[3], cl[2], cl[1], cl[0]};
          mq.push_back(m_new);
          if (m_ec < 65535) m_ec++;
        end else if (m_dc < 65535) begin
          m_dc++;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      check("valid", 32'(out_valid), 32'(busy));
      if (busy) begin
        check("idx", 32'(out_idx), 32'(bq[0][W+2:W]));
        check("cluster", 32'(out_cluster), 32'(bq[0][W-1:0]));
        check("last", 32'(out_last), 32'(bq.size() == 1));
      end else begin
        check("idle_outs", {17'd0, out_last, out_idx, out_cluster}, 32'd0);
      end
      check("event_count", 32'(event_count), 32'(m_ec));
      check("drop_count", 32'(drop_count), 32'(m_dc));
      check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      if (out_valid && out_ready) log_q.push_back({out_last, out_idx, out_cluster});
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_ev(input logic [7:0] m, input logic en);
    match     = m;
    any_match = |m;
    enable    = en;
  endtask

  task automatic clear_in;
    match     = 8'd0;
    any_match = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
    log_q.delete();
  endtask

  task automatic check_log(input string name, input int n, input logic [W+3:0] exp);
    logic [W+3:0] v;
    v = (log_q.size() > n) ? log_q[n] : '1;
    check(name, 32'(v), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) cl[k] = 14'(16'h1111 * (k + 1));
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ec", 32'(event_count), 32'd0);
    check("rst_dc", 32'(drop_count), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);

    // Single event, ready high throughout
    out_ready = 1'b1;
    cl[0] = 14'h0010; cl[2] = 14'h0020; cl[5] = 14'h0030;
    set_ev(8'b0010_0101, 1'b1);
    tick();
    clear_in();
    check("lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("lat_e1", 32'(out_valid), 32'd1);
    check("lat_idx", 32'(out_idx), 32'd0);
    repeat (4) tick();
    check("t1_nbeats", 32'(log_q.size()), 32'd3);
    check_log("t1_b0", 0, {1'b0, 3'd0, 14'h0010});
    check_log("t1_b1", 1, {1'b0, 3'd2, 14'h0020});
    check_log("t1_b2", 2, {1'b1, 3'd5, 14'h0030});
    check("t1_ec", 32'(event_count), 32'd1);

    // Backpressure on the first beat
    log_q.delete();
    out_ready = 1'b0;
    set_ev(8'b0010_0101, 1'b1);
    tick();
    clear_in();
    tick();
    repeat (3) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx", 32'(out_idx), 32'd0);
      check("bp_cluster", 32'(out_cluster), 32'h10);
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();
    check("t2_nbeats", 32'(log_q.size()), 32'd3);
    check_log("t2_b0", 0, {1'b0, 3'd0, 14'h0010});
    check_log("t2_b1", 1, {1'b0, 3'd2, 14'h0020});
    check_log("t2_b2", 2, {1'b1, 3'd5, 14'h0030});
    check("t2_ec", 32'(event_count), 32'd2);

    // Overflow: DEPTH+2 single-cluster events with the output stalled
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < DEPTH + 2; n++) begin
      cl[0] = 14'(16'h0100 + n);
      set_ev(8'h01, 1'b1);
      tick();
    end
    clear_in();
    check("ovf_ec", 32'(event_count), 32'd5);
    check("ovf_dc", 32'(drop_count), 32'd1);
    check("ovf_full", 32'(fifo_full), 32'd1);
    out_ready = 1'b1;
    repeat (12) tick();
    check("ovf_nbeats", 32'(log_q.size()), 32'd5);
    for (int n = 0; n < 5; n++)
      check_log("ovf_order", n, {1'b1, 3'd0, 14'(16'h0100 + n)});

    // Push into a full FIFO on the edge the head is popped
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cl[0] = 14'(16'h0200 + n);
      set_ev(8'h01, 1'b1);
      tick();
    end
    clear_in();
    check("sim_full", 32'(fifo_full), 32'd1);
    out_ready = 1'b1;
    tick();
    check("sim_idle", 32'(out_valid), 32'd0);
    cl[0] = 14'h0205;
    set_ev(8'h01, 1'b1);
    tick();
    clear_in();
    check("sim_dc", 32'(drop_count), 32'd0);
    check("sim_ec", 32'(event_count), 32'd6);
    check("sim_full2", 32'(fifo_full), 32'd1);
    repeat (12) tick();
    check("sim_nbeats", 32'(log_q.size()), 32'd6);
    for (int n = 0; n < 6; n++)
      check_log("sim_order", n, {1'b1, 3'd0, 14'(16'h0200 + n)});

    // enable low blocks new events but the current one still drains
    do_reset();
    out_ready = 1'b0;
    cl[0] = 14'h0011; cl[1] = 14'h0022;
    set_ev(8'h03, 1'b1);
    tick();
    clear_in();
    tick();
    set_ev(8'hFF, 1'b0);
    out_ready = 1'b1;
    repeat (4) tick();
    clear_in();
    enable = 1'b1;
    check("en_ec", 32'(event_count), 32'd1);
    check("en_dc", 32'(drop_count), 32'd0);
    check("en_nbeats", 32'(log_q.size()), 32'd2);
    check_log("en_b0", 0, {1'b0, 3'd0, 14'h0011});
    check_log("en_b1", 1, {1'b1, 3'd1, 14'h0022});

    // Reset in the middle of an event
    do_reset();
    out_ready = 1'b1;
    cl[0] = 14'h0010; cl[2] = 14'h0020; cl[5] = 14'h0030;
    set_ev(8'b0010_0101, 1'b1);
    tick();
    clear_in();
    tick();
    tick();
    check("mid_idx", 32'(out_idx), 32'd2);
    reset = 1'b1;
    set_ev(8'h80, 1'b1);
    tick();
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_ec", 32'(event_count), 32'd0);
    check("mr_dc", 32'(drop_count), 32'd0);
    check("mr_full", 32'(fifo_full), 32'd0);
    reset = 1'b0;
    clear_in();
    tick();
    check("mr_valid2", 32'(out_valid), 32'd0);
    log_q.delete();
    cl[7] = 14'h3FFF;
    set_ev(8'h80, 1'b1);
    tick();
    clear_in();
    check("mr_lat0", 32'(out_valid), 32'd0);
    tick();
    check("mr_lat1", 32'(out_valid), 32'd1);
    check("mr_idx", 32'(out_idx), 32'd7);
    check("mr_cluster", 32'(out_cluster), 32'h3FFF);
    check("mr_last", 32'(out_last), 32'd1);
    repeat (3) tick();
    check("mr_nbeats", 32'(log_q.size()), 32'd1);
    check("mr_ec2", 32'(event_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
